// File: rtl/md_req_adapter.sv
// Valid/ready initiator for the mult_div core with a 2-entry response FIFO.
// Optional WAIT watchdog enabled by defining MD_ADAPTER_TIMEOUT_EN.
module md_req_adapter #(
    parameter int unsigned InDw          = 8,
    parameter int unsigned TimeoutCycles = 64
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [InDw-1:0]   req_a_i,
    input  logic [InDw-1:0]   req_b_i,
    input  logic [1:0]        req_tc_mode_i,
    input  logic              req_operator_i,
    output logic              md_en_o,
    output logic [InDw-1:0]   md_a_o,
    output logic [InDw-1:0]   md_b_o,
    output logic [1:0]        md_tc_mode_o,
    output logic              md_operator_o,
    input  logic              md_busy_i,
    input  logic              md_valid_i,
    input  logic [2*InDw-1:0] md_c_i,
    input  logic              md_div_by_zero_i,
    input  logic              md_div_overflow_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [2*InDw-1:0] resp_c_o,
    output logic              resp_operator_o,
    output logic              resp_div_by_zero_o,
    output logic              resp_div_overflow_o,
    output logic              resp_timeout_o
);

    localparam int unsigned EntW = 2 * InDw + 4;

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e            state_q;
    logic [InDw-1:0]   a_q, b_q;
    logic [1:0]        tc_q;
    logic              op_q;
    logic [EntW-1:0]   head_q, tail_q;
    logic [1:0]        count_q;
    logic [1:0]        wsel;
    logic              push, pop, timeout_hit;
    logic [EntW-1:0]   push_data;

`ifdef MD_ADAPTER_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TimeoutCycles);
    logic [CntW-1:0] tcnt_q;

    // md_valid_i on the expiry cycle takes priority over the timeout.
    assign timeout_hit = (state_q == StWait) & ~md_valid_i &
                         (tcnt_q == CntW'(TimeoutCycles - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tcnt_q <= '0;
        end else if (state_q != StWait) begin
            tcnt_q <= '0;
        end else begin
            tcnt_q <= tcnt_q + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    assign push      = (state_q == StWait) & (md_valid_i | timeout_hit);
    assign push_data = md_valid_i ?
                       {md_c_i, op_q, md_div_by_zero_i, md_div_overflow_i, 1'b0} :
                       {{(2 * InDw){1'b0}}, op_q, 1'b0, 1'b0, 1'b1};
    assign pop       = (count_q != 2'd0) & resp_ready_i;
    // Slot a push lands in once a simultaneous pop has shifted the queue.
    assign wsel      = count_q - {1'b0, pop};

    assign req_ready_o = (state_q == StIdle) & ~count_q[1];
    assign md_en_o     = (state_q == StIssue) & ~md_busy_i;

    assign md_a_o        = a_q;
    assign md_b_o        = b_q;
    assign md_tc_mode_o  = tc_q;
    assign md_operator_o = op_q;

    assign resp_valid_o = (count_q != 2'd0);
    assign {resp_c_o, resp_operator_o, resp_div_by_zero_o, resp_div_overflow_o,
            resp_timeout_o} = head_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            tc_q    <= '0;
            op_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid_i && req_ready_o) begin
                        a_q     <= req_a_i;
                        b_q     <= req_b_i;
                        tc_q    <= req_tc_mode_i;
                        op_q    <= req_operator_i;
                        state_q <= StIssue;
                    end
                end
                StIssue: begin
                    if (!md_busy_i) state_q <= StWait;
                end
                StWait: begin
                    if (push) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (pop) head_q <= tail_q;
            if (push) begin
                if (wsel[0]) tail_q <= push_data;
                else         head_q <= push_data;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_md_req_adapter.sv
// Directed bench for md_req_adapter; the bench plays the mult_div core and
// checks responses against a queue of expected entries.
module tb_md_req_adapter;

    localparam int unsigned InDw          = 8;
    localparam int unsigned TimeoutCycles = 64;

    typedef struct packed {
        logic [15:0] c;
        logic        op;
        logic        dbz;
        logic        ovf;
        logic        to;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [7:0]  req_a_i = '0, req_b_i = '0;
    logic [1:0]  req_tc_mode_i = '0;
    logic        req_operator_i = 1'b0;
    logic        md_en_o;
    logic [7:0]  md_a_o, md_b_o;
    logic [1:0]  md_tc_mode_o;
    logic        md_operator_o;
    logic        md_busy_i = 1'b0;
    logic        md_valid_i = 1'b0;
    logic [15:0] md_c_i = '0;
    logic        md_div_by_zero_i = 1'b0, md_div_overflow_i = 1'b0;
    logic        resp_valid_o;
    logic        resp_ready_i = 1'b0;
    logic [15:0] resp_c_o;
    logic        resp_operator_o, resp_div_by_zero_o, resp_div_overflow_o, resp_timeout_o;

    int    total = 0;
    int    bad = 0;
    resp_t exp_q[$];
    resp_t mon_e;

    always #5 clk = ~clk;

    md_req_adapter #(.InDw(InDw), .TimeoutCycles(TimeoutCycles)) dut (
        .clk_i              (clk),
        .rst_ni             (rst_ni),
        .req_valid_i        (req_valid_i),
        .req_ready_o        (req_ready_o),
        .req_a_i            (req_a_i),
        .req_b_i            (req_b_i),
        .req_tc_mode_i      (req_tc_mode_i),
        .req_operator_i     (req_operator_i),
        .md_en_o            (md_en_o),
        .md_a_o             (md_a_o),
        .md_b_o             (md_b_o),
        .md_tc_mode_o       (md_tc_mode_o),
        .md_operator_o      (md_operator_o),
        .md_busy_i          (md_busy_i),
        .md_valid_i         (md_valid_i),
        .md_c_i             (md_c_i),
        .md_div_by_zero_i   (md_div_by_zero_i),
        .md_div_overflow_i  (md_div_overflow_i),
        .resp_valid_o       (resp_valid_o),
        .resp_ready_i       (resp_ready_i),
        .resp_c_o           (resp_c_o),
        .resp_operator_o    (resp_operator_o),
        .resp_div_by_zero_o (resp_div_by_zero_o),
        .resp_div_overflow_o(resp_div_overflow_o),
        .resp_timeout_o     (resp_timeout_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the rising edge; outputs are checked on the falling edge.
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_ni && resp_valid_o && resp_ready_i) begin
            if (exp_q.size() == 0) begin
                chk("resp_unexpected", exp_q.size(), 1);
            end else begin
                mon_e = exp_q.pop_front();
                chk("resp_entry", {12'b0, resp_c_o, resp_operator_o, resp_div_by_zero_o,
                                   resp_div_overflow_o, resp_timeout_o}, {12'b0, mon_e});
            end
        end
    end

    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] tc,
                         input logic op, input logic [15:0] c, input logic dbz,
                         input logic ovf, input int bc, input int lat);
        int    n;
        resp_t r;
        next();
        req_valid_i = 1'b1;
        req_a_i = a;
        req_b_i = b;
        req_tc_mode_i = tc;
        req_operator_i = op;
        md_busy_i = (bc > 0);
        mid();
        n = 0;
        while (!req_ready_o && n < 50) begin
            next();
            mid();
            n++;
        end
        chk("req_ready", req_ready_o, 1);
        r = {c, op, dbz, ovf, 1'b0};
        exp_q.push_back(r);
        next();
        req_valid_i = 1'b0;
        req_a_i = 8'($urandom);
        req_b_i = 8'($urandom);
        req_tc_mode_i = ~tc;
        req_operator_i = ~op;
        for (int i = 0; i < bc; i++) begin
            mid();
            chk("en_while_busy", md_en_o, 0);
            chk("a_hold_busy", md_a_o, a);
            next();
            if (i == bc - 1) md_busy_i = 1'b0;
        end
        mid();
        chk("en_pulse", md_en_o, 1);
        chk("md_operands", {md_a_o, md_b_o, md_tc_mode_o, md_operator_o}, {a, b, tc, op});
        next();
        mid();
        chk("en_once", md_en_o, 0);
        repeat (lat) begin
            next();
            mid();
        end
        next();
        md_valid_i = 1'b1;
        md_c_i = c;
        md_div_by_zero_i = dbz;
        md_div_overflow_i = ovf;
        mid();
        chk("operands_stable", {md_a_o, md_b_o}, {a, b});
        next();
        md_valid_i = 1'b0;
        md_c_i = 16'($urandom);
        md_div_by_zero_i = 1'b0;
        md_div_overflow_i = 1'b0;
        mid();
        chk("resp_valid_after", resp_valid_o, 1);
    endtask

    initial begin
        int w;
        resp_t r;

        repeat (2) mid();
        chk("rst_resp_valid", resp_valid_o, 0);
        chk("rst_md_en", md_en_o, 0);
        chk("rst_md_ops", {md_a_o, md_b_o, md_tc_mode_o, md_operator_o}, 0);
        chk("rst_resp", {resp_c_o, resp_operator_o, resp_div_by_zero_o, resp_div_overflow_o,
                         resp_timeout_o}, 0);
        chk("rst_req_ready", req_ready_o, 1);
        next();
        rst_ni = 1'b1;
        resp_ready_i = 1'b1;

        do_op(8'd200, 8'd3, 2'b00, 1'b0, 16'h0258, 1'b0, 1'b0, 0, 2);
        do_op(8'd100, 8'd7, 2'b00, 1'b1, 16'h020E, 1'b0, 1'b0, 0, 3);
        do_op(8'd5, 8'd0, 2'b00, 1'b1, 16'h05FF, 1'b1, 1'b0, 0, 1);
        do_op(8'h80, 8'hFF, 2'b11, 1'b1, 16'h0080, 1'b0, 1'b1, 3, 2);

        // Stray core valid while idle must not create a response.
        next();
        md_valid_i = 1'b1;
        md_c_i = 16'hBEEF;
        mid();
        next();
        md_valid_i = 1'b0;
        mid();
        chk("stray_valid_ignored", resp_valid_o, 0);

        // Back-pressure: two results parked, then drained one at a time.
        next();
        resp_ready_i = 1'b0;
        do_op(8'd12, 8'd12, 2'b00, 1'b0, 16'h0090, 1'b0, 1'b0, 0, 1);
        do_op(8'd50, 8'd5, 2'b00, 1'b1, 16'h000A, 1'b0, 1'b0, 0, 0);
        chk("bp_full_not_ready", req_ready_o, 0);
        next();
        resp_ready_i = 1'b1;
        mid();
        chk("bp_pop_cycle_ready", req_ready_o, 0);
        next();
        resp_ready_i = 1'b0;
        mid();
        chk("bp_ready_after_pop", req_ready_o, 1);
        chk("bp_second_held", resp_valid_o, 1);
        next();
        resp_ready_i = 1'b1;
        mid();
        next();
        mid();
        chk("bp_drained", resp_valid_o, 0);

`ifdef MD_ADAPTER_TIMEOUT_EN
        next();
        req_valid_i = 1'b1;
        req_a_i = 8'd3;
        req_b_i = 8'd4;
        req_operator_i = 1'b1;
        req_tc_mode_i = 2'b00;
        mid();
        chk("to_req_ready", req_ready_o, 1);
        r = {16'h0000, 1'b1, 1'b0, 1'b0, 1'b1};
        exp_q.push_back(r);
        next();
        req_valid_i = 1'b0;
        mid();
        chk("to_en", md_en_o, 1);
        next();
        mid();
        w = 1;
        while (!resp_valid_o && w < 200) begin
            next();
            mid();
            w++;
        end
        chk("to_wait_cycles", w, TimeoutCycles + 1);
        do_op(8'd7, 8'd6, 2'b00, 1'b0, 16'h002A, 1'b0, 1'b0, 0, 1);
`endif

        // Reset while waiting on the core; the late result must be dropped.
        next();
        req_valid_i = 1'b1;
        req_a_i = 8'd9;
        req_b_i = 8'd9;
        req_operator_i = 1'b0;
        req_tc_mode_i = 2'b00;
        mid();
        next();
        req_valid_i = 1'b0;
        mid();
        chk("rstmid_en", md_en_o, 1);
        next();
        mid();
        next();
        rst_ni = 1'b0;
        mid();
        chk("rstmid_ops_cleared", {md_a_o, md_b_o}, 0);
        chk("rstmid_ready", req_ready_o, 1);
        next();
        rst_ni = 1'b1;
        md_valid_i = 1'b1;
        md_c_i = 16'h0051;
        mid();
        next();
        md_valid_i = 1'b0;
        repeat (3) begin
            next();
            mid();
        end
        chk("rstmid_no_resp", resp_valid_o, 0);
        do_op(8'd9, 8'd9, 2'b00, 1'b0, 16'h0051, 1'b0, 1'b0, 0, 2);

        repeat (2) begin
            next();
            mid();
        end
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
